// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Imported by the write arbiter and by the top level.
package regfile_pkg;

  localparam int WORD_SIZE_DEF = 18;
  localparam int SP_INDEX_DEF  = 7;

  // Address width for n registers, never below one bit.
  function automatic int addr_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/regfile_wr_arb.sv
// Per-register next value and write strobe from ports A, B and SP adjust.
// A beats B beats SP adjust; out-of-range addresses match no register.
module regfile_wr_arb
  import regfile_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int REG_COUNT = 8,
  parameter int SP_INDEX  = SP_INDEX_DEF,
  parameter int ADDR_W    = addr_w(REG_COUNT)
) (
  input  logic [REG_COUNT-1:0][WORD_SIZE-1:0] regs_q_i,
  input  logic                                wa_en_i,
  input  logic [ADDR_W-1:0]                   wa_addr_i,
  input  logic [WORD_SIZE-1:0]                wa_data_i,
  input  logic                                wb_en_i,
  input  logic [ADDR_W-1:0]                   wb_addr_i,
  input  logic [WORD_SIZE-1:0]                wb_data_i,
  input  logic                                sp_adj_en_i,
  input  logic [WORD_SIZE-1:0]                sp_adj_i,
  output logic [REG_COUNT-1:0][WORD_SIZE-1:0] regs_d_o,
  output logic [REG_COUNT-1:0]                we_o
);

  always_comb begin
    regs_d_o = regs_q_i;
    we_o     = '0;
    for (int r = 0; r < REG_COUNT; r++) begin
      if (wa_en_i && wa_addr_i == ADDR_W'(r)) begin
        regs_d_o[r] = wa_data_i;
        we_o[r]     = 1'b1;
      end else if (wb_en_i && wb_addr_i == ADDR_W'(r)) begin
        regs_d_o[r] = wb_data_i;
        we_o[r]     = 1'b1;
      end else if (r == SP_INDEX && sp_adj_en_i) begin
        regs_d_o[r] = regs_q_i[r] + sp_adj_i;
        we_o[r]     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: N reads, two prioritised writes, SP adjust,
// optional write-to-read bypass and a per-register busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WORD_SIZE  = WORD_SIZE_DEF,
  parameter int REG_COUNT  = 8,
  parameter int READ_PORTS = 3,
  parameter int BYPASS     = 1,
  parameter int SP_INDEX   = SP_INDEX_DEF,
  parameter logic [WORD_SIZE-1:0] SP_RESET = '0,
  localparam int ADDR_W    = addr_w(REG_COUNT)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [READ_PORTS*ADDR_W-1:0]     rd_addr,
  output logic [READ_PORTS*WORD_SIZE-1:0]  rd_data,
  output logic [READ_PORTS-1:0]            rd_busy,
  input  logic                             wa_en,
  input  logic [ADDR_W-1:0]                wa_addr,
  input  logic [WORD_SIZE-1:0]             wa_data,
  input  logic                             wb_en,
  input  logic [ADDR_W-1:0]                wb_addr,
  input  logic [WORD_SIZE-1:0]             wb_data,
  input  logic                             sp_adj_en,
  input  logic [WORD_SIZE-1:0]             sp_adj,
  input  logic                             sb_set_en,
  input  logic [ADDR_W-1:0]                sb_set_addr,
  output logic [WORD_SIZE-1:0]             sp_value
);

  logic [REG_COUNT-1:0][WORD_SIZE-1:0] regs_q, regs_d;
  logic [REG_COUNT-1:0]                we;
  logic [REG_COUNT-1:0]                busy_q, busy_d;

  regfile_wr_arb #(
    .WORD_SIZE (WORD_SIZE),
    .REG_COUNT (REG_COUNT),
    .SP_INDEX  (SP_INDEX),
    .ADDR_W    (ADDR_W)
  ) u_arb (
    .regs_q_i    (regs_q),
    .wa_en_i     (wa_en),
    .wa_addr_i   (wa_addr),
    .wa_data_i   (wa_data),
    .wb_en_i     (wb_en),
    .wb_addr_i   (wb_addr),
    .wb_data_i   (wb_data),
    .sp_adj_en_i (sp_adj_en),
    .sp_adj_i    (sp_adj),
    .regs_d_o    (regs_d),
    .we_o        (we)
  );

  // Set after clear: a new load to the same register stays outstanding.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < REG_COUNT; r++) begin
      if (wb_en && wb_addr == ADDR_W'(r))
        busy_d[r] = 1'b0;
      if (sb_set_en && sb_set_addr == ADDR_W'(r))
        busy_d[r] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < REG_COUNT; r++)
        regs_q[r] <= (r == SP_INDEX) ? SP_RESET : '0;
      busy_q <= '0;
    end else begin
      for (int r = 0; r < REG_COUNT; r++)
        if (we[r]) regs_q[r] <= regs_d[r];
      busy_q <= busy_d;
    end
  end

  assign sp_value = regs_q[SP_INDEX];

  for (genvar i = 0; i < READ_PORTS; i++) begin : g_rd
    logic [ADDR_W-1:0]    a, a_ok;
    logic                 ok, wb_hit;
    logic [WORD_SIZE-1:0] src;

    assign a      = rd_addr[i*ADDR_W +: ADDR_W];
    assign ok     = int'(a) < REG_COUNT;
    assign a_ok   = ok ? a : '0;
    assign wb_hit = (BYPASS != 0) && wb_en && wb_addr == a;
    assign src    = (BYPASS != 0) ? regs_d[a_ok] : regs_q[a_ok];

    assign rd_data[i*WORD_SIZE +: WORD_SIZE] = ok ? src : '0;
    assign rd_busy[i] = ok && busy_q[a_ok] && !wb_hit;
  end

endmodule
